arb4_sel: RTL

ARB4_SEL -- requirements
Module: arb4_sel

---
 rtl/arb4_sel.sv | 79 +++++++
 1 files changed

// File: rtl/arb4_sel.sv
// arb4_sel: 4-way round-robin arbiter with a hold limit and registered mux selects
module arb4_sel #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, ptr_nx, own, own_nx, off, win;
  logic [CNT_W-1:0] hold, hold_nx;
  logic [3:0] gnt_nx;
  logic [5:0] dbl;
  logic [2:0] rot;
  logic to_nx, at_max, rel;
  // round-robin winner: rotate requests so ptr sits at bit 0, take the first set bit
  always_comb begin
    dbl = {req[1:0], req};
    rot = dbl[{1'b0, ptr} +: 3];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win = ptr + off;
    at_max = hold == CNT_W'(MAX_HOLD);
    rel = done || !req[own] || at_max;
  end
  // next-state: arbitrate in IDLE, count and release in GRANT
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    own_nx = own;
    ptr_nx = ptr;
    hold_nx = hold;
    to_nx = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_nx = GRANT;
        gnt_nx = 4'b0001 << win;
        own_nx = win;
        hold_nx = CNT_W'(1);
      end
    end else if (rel) begin
      state_nx = IDLE;
      gnt_nx = 4'b0000;
      ptr_nx = own + 2'd1;
      hold_nx = '0;
      to_nx = at_max && !done && req[own];
    end else begin
      hold_nx = hold + CNT_W'(1);
    end
  end
  // state register; reset clears everything without waiting for a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt <= 4'b0000;
      own <= 2'd0;
      ptr <= 2'd0;
      hold <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      own <= own_nx;
      ptr <= ptr_nx;
      hold <= hold_nx;
      timeout <= to_nx;
    end
  end
  assign busy = state == GRANT;
  assign s0 = own[0];
  assign s1 = own[1];
endmodule
